// File: rtl/hex_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one digit lit per dwell period, display word
// double-buffered so new values appear only at a frame boundary (no tearing).
module hex_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_BLANK = 7'h7F;
  localparam logic [6:0]       SEG_ZERO  = 7'h40;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] a;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      a[i] = (idx != IDX_W'(i));
    end
    return a;
  endfunction

  logic [CNT_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         pend_word_q, pend_word_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  tick;
  logic                  boundary;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic                  zero_run;

  // Prescaler and digit sequencing
  always_comb begin
    tick       = (tick_cnt_q == CNT_LAST);
    boundary   = tick && (idx_q == IDX_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: a load in the boundary cycle bypasses the pending slot
  always_comb begin
    shadow_d     = shadow_q;
    pend_word_d  = pend_word_q;
    pending_d    = pending_q;
    frame_done_d = boundary;
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        shadow_d = data_in;
      end else if (pending_q) begin
        shadow_d = pend_word_q;
      end
    end else if (load) begin
      pend_word_d = data_in;
      pending_d   = 1'b1;
    end
  end

  // Digit value and leading-zero run, scanned from the most significant digit down
  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (shadow_d[4*i +: 4] == 4'h0);
      if (idx_d == IDX_W'(i)) begin
        cur_nib   = shadow_d[4*i +: 4];
        cur_blank = blank_lz && zero_run && (i != 0);
      end
    end
  end

  // Outputs are built from next-state idx/shadow so seg and an switch together
  always_comb begin
    seg_d = cur_blank ? SEG_BLANK : seg_encode(cur_nib);
    an_d  = anode_sel(idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      pend_word_q  <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_ZERO;
      an_q         <= anode_sel('0);
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pend_word_q  <= pend_word_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule
